// File: rtl/sync_pkg.sv
// Shared constants and helpers for the synchronizer / deglitch blocks.
package sync_pkg;

  // Fewest flops that still give a usable metastability settling window.
  localparam int SYNC_STAGE_MIN = 2;

  // Attribute name tools look for on synchronizer flops; kept here so the
  // chain attribute and any constraint scripts agree on one spelling.
  localparam string SYNC_CHAIN_ATTR = "ASYNC_REG";

  // Width of a counter that must hold values 0..n, never narrower than 1 bit.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sync_deglitch_ch.sv
// One channel: flop-chain synchronizer, stability filter, registered edge pulses.
module sync_deglitch_ch
  import sync_pkg::*;
#(
  parameter int   STAGE   = 3,
  parameter int   FILT    = 4,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic srst_i,
  input  logic din_i,
  input  logic bypass_i,
  output logic dout_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int             CW       = cnt_width(FILT);
  localparam logic [CW-1:0]  CNT_LAST = CW'(FILT - 1);

  // Chain flops must stay adjacent with nothing between stages.
  (* ASYNC_REG = "TRUE", DONT_TOUCH = "TRUE" *)
  logic [STAGE-1:0] s_q;

  logic          sync;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dout_q, dout_d;
  logic          rise_q, fall_q;

  assign sync = s_q[STAGE-1];

  // Synchronizer chain: pure shift, loaded with the reset level on any clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         s_q <= {STAGE{RST_VAL}};
    else if (srst_i) s_q <= {STAGE{RST_VAL}};
    else             s_q <= {s_q[STAGE-2:0], din_i};
  end

  // Filter decision: follow sync only after FILT consecutive disagreeing cycles.
  always_comb begin
    dout_d = dout_q;
    cnt_d  = cnt_q;
    if (bypass_i) begin
      dout_d = sync;
      cnt_d  = '0;
    end else if (sync == dout_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      dout_d = sync;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Filter state and edge pulses; pulses are derived from the same update so
  // they line up with the cycle dout first shows its new value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      dout_q <= RST_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else if (srst_i) begin
      cnt_q  <= '0;
      dout_q <= RST_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
      rise_q <= dout_d & ~dout_q;
      fall_q <= ~dout_d & dout_q;
    end
  end

  assign dout_o = dout_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/sync_deglitch.sv
// Multi-channel synchronizer with per-channel glitch filter and edge pulses.
module sync_deglitch
  import sync_pkg::*;
#(
  parameter int             NCH     = 4,
  parameter int             STAGE   = 3,
  parameter int             FILT    = 4,
  parameter logic [NCH-1:0] RST_VAL = {NCH{1'b0}}
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           srst,
  input  logic [NCH-1:0] din,
  input  logic [NCH-1:0] cfg_bypass,
  output logic [NCH-1:0] dout,
  output logic [NCH-1:0] rise,
  output logic [NCH-1:0] fall
);

  // Reject configurations that cannot synchronize or filter.
  if (STAGE < SYNC_STAGE_MIN) begin : g_chk_stage
    $error("sync_deglitch: STAGE must be >= 2");
  end
  if (FILT < 1) begin : g_chk_filt
    $error("sync_deglitch: FILT must be >= 1");
  end
  if (NCH < 1) begin : g_chk_nch
    $error("sync_deglitch: NCH must be >= 1");
  end

  // Channels are fully independent; each gets its own reset level bit.
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    sync_deglitch_ch #(
      .STAGE   (STAGE),
      .FILT    (FILT),
      .RST_VAL (RST_VAL[i])
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .srst_i   (srst),
      .din_i    (din[i]),
      .bypass_i (cfg_bypass[i]),
      .dout_o   (dout[i]),
      .rise_o   (rise[i]),
      .fall_o   (fall[i])
    );
  end

endmodule
